alu_share_arbiter: RTL and testbench

// - Shares one combinational 32-bit ALU among NUM_REQ requesters (e.g. issue slots, AGU, branch unit).
// - Round-robin arbitration; the winner's operands drive the ALU; the result is registered into a

---
 rtl/alu_share_arbiter_if.sv | 32 +++
 rtl/alu_share_arbiter.sv | 76 +++++++
 tb/tb_alu_share_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU and response signals for the shared-ALU arbiter.
// slave: arbiter side. master: requesters, ALU and response consumer side.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_op1;
    logic [NUM_REQ*DATA_W-1:0] req_op2;
    logic [NUM_REQ*4-1:0]      req_sel;
    logic [DATA_W-1:0]         alu_op1;
    logic [DATA_W-1:0]         alu_op2;
    logic [3:0]                alu_sel;
    logic [DATA_W-1:0]         alu_out;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_err;

    modport slave (
        input  req_valid, req_op1, req_op2, req_sel, alu_out, rsp_ready,
        output req_ready, alu_op1, alu_op2, alu_sel, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport master (
        output req_valid, req_op1, req_op2, req_sel, alu_out, rsp_ready,
        input  req_ready, alu_op1, alu_op2, alu_sel, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NUM_REQ requesters,
// with the selected result registered into a single valid/ready response slot.
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input logic                clk,
    input logic                rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t           state;
    logic [ID_W-1:0] rr_ptr;
    logic            slot_free;
    logic            grant;
    logic [ID_W-1:0] winner;
    logic            sel_bad;

    assign slot_free = (state == EMPTY) || bus.rsp_ready;

    always_comb begin
        int unsigned idx;
        grant  = 1'b0;
        winner = '0;
        idx    = 0;
        if (slot_free) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = (32'(rr_ptr) + k) % NUM_REQ;
                if (!grant && bus.req_valid[idx]) begin
                    grant  = 1'b1;
                    winner = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.alu_op1   = '0;
        bus.alu_op2   = '0;
        bus.alu_sel   = '0;
        if (grant) begin
            bus.req_ready[winner] = 1'b1;
            bus.alu_op1 = bus.req_op1[32'(winner)*DATA_W +: DATA_W];
            bus.alu_op2 = bus.req_op2[32'(winner)*DATA_W +: DATA_W];
            bus.alu_sel = bus.req_sel[32'(winner)*4 +: 4];
        end
    end

    // Codes above COPY1 (10) are undefined for the ALU; its output is discarded.
    assign sel_bad       = grant && (bus.alu_sel > 4'd10);
    assign bus.rsp_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            rr_ptr       <= '0;
            bus.rsp_data <= '0;
            bus.rsp_id   <= '0;
            bus.rsp_err  <= 1'b0;
        end else if (grant) begin
            state        <= FULL;
            rr_ptr       <= ID_W'((32'(winner) + 1) % NUM_REQ);
            bus.rsp_data <= sel_bad ? '0 : bus.alu_out;
            bus.rsp_id   <= winner;
            bus.rsp_err  <= sel_bad;
        end else if (state == FULL && bus.rsp_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; a behavioural ALU sits on the alu_* side.
module tb_alu_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Undefined codes yield junk so that the arbiter's forced zero is observable.
    always_comb begin
        case (bus.alu_sel)
            4'd0:    bus.alu_out = bus.alu_op1 + bus.alu_op2;
            4'd1:    bus.alu_out = bus.alu_op1 - bus.alu_op2;
            4'd2:    bus.alu_out = bus.alu_op1 & bus.alu_op2;
            4'd3:    bus.alu_out = bus.alu_op1 | bus.alu_op2;
            4'd4:    bus.alu_out = bus.alu_op1 ^ bus.alu_op2;
            4'd5:    bus.alu_out = {31'd0, $signed(bus.alu_op1) < $signed(bus.alu_op2)};
            4'd6:    bus.alu_out = {31'd0, bus.alu_op1 < bus.alu_op2};
            4'd7:    bus.alu_out = bus.alu_op1 << bus.alu_op2[4:0];
            4'd8:    bus.alu_out = bus.alu_op1 >> bus.alu_op2[4:0];
            4'd9:    bus.alu_out = $signed(bus.alu_op1) >>> bus.alu_op2[4:0];
            4'd10:   bus.alu_out = bus.alu_op1;
            default: bus.alu_out = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel);
        bus.req_op1[i*DATA_W +: DATA_W] = a;
        bus.req_op2[i*DATA_W +: DATA_W] = b;
        bus.req_sel[i*4 +: 4]           = sel;
        bus.req_valid[i]                = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single request through the slot with rsp_ready held high.
    task automatic do_op(input string tag, input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] sel,
                         input logic [31:0] exp_data, input logic exp_err);
        set_req(i, a, b, sel);
        #1;
        check({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << i));
        tick();
        bus.req_valid = '0;
        check({tag, "_data"}, bus.rsp_data, exp_data);
        check({tag, "_id"}, 32'(bus.rsp_id), 32'(i));
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b0;
        #12;
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_data", bus.rsp_data, 32'd0);
        check("rst_id", 32'(bus.rsp_id), 32'd0);
        check("rst_err", 32'(bus.rsp_err), 32'd0);
        check("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // All four continuously valid: grants 0,1,2,3,0 and rsp_id one cycle later.
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(100 + i), 32'd0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ready", 32'(bus.req_ready), 32'(1 << (k % NUM_REQ)));
            tick();
            check("rr_valid", 32'(bus.rsp_valid), 32'd1);
            check("rr_id", 32'(bus.rsp_id), 32'(k % NUM_REQ));
            check("rr_data", bus.rsp_data, 32'(100 + (k % NUM_REQ)));
        end
        bus.req_valid = '0;

        // Single request ADD 5+7.
        set_req(0, 32'd5, 32'd7, 4'd0);
        #1;
        check("single_ready", 32'(bus.req_ready), 32'h1);
        check("single_alu_op1", bus.alu_op1, 32'd5);
        tick();
        bus.req_valid = '0;
        check("single_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_data", bus.rsp_data, 32'd12);
        check("single_id", 32'(bus.rsp_id), 32'd0);
        check("single_err", 32'(bus.rsp_err), 32'd0);

        // Backpressure: result held while req1 SUB 3-5 waits.
        bus.rsp_ready = 1'b0;
        set_req(1, 32'd3, 32'd5, 4'd1);
        #1;
        check("bp_ready0", 32'(bus.req_ready), 32'd0);
        check("bp_alu_sel", 32'(bus.alu_sel), 32'd0);
        tick();
        tick();
        check("bp_ready1", 32'(bus.req_ready), 32'd0);
        check("bp_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_data", bus.rsp_data, 32'h0000_000C);
        check("bp_id", 32'(bus.rsp_id), 32'd0);
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        check("bp_data2", bus.rsp_data, 32'hFFFF_FFFE);
        check("bp_id2", 32'(bus.rsp_id), 32'd1);
        check("bp_valid2", 32'(bus.rsp_valid), 32'd1);
        tick();
        check("drain_valid", 32'(bus.rsp_valid), 32'd0);
        check("idle_alu_op1", bus.alu_op1, 32'd0);

        // ALU operations through the arbiter.
        do_op("slt", 3, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd1, 1'b0);
        do_op("sltu", 3, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'd0, 1'b0);
        do_op("sra", 0, 32'h8000_0000, 32'h24, 4'd9, 32'hF800_0000, 1'b0);
        do_op("sll", 1, 32'h0000_0003, 32'd4, 4'd7, 32'h0000_0030, 1'b0);

        // Illegal select, then a legal request on the same requester.
        do_op("illegal", 2, 32'd5, 32'd7, 4'd13, 32'd0, 1'b1);
        do_op("legal", 2, 32'h0000_00F0, 32'h0000_000F, 4'd3, 32'h0000_00FF, 1'b0);

        // Async reset while the slot is FULL: no clock edge between assert and check.
        bus.rsp_ready = 1'b0;
        check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.rsp_valid), 32'd0);
        check("arst_data", bus.rsp_data, 32'd0);
        check("arst_id", 32'(bus.rsp_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(1, 32'd2, 32'd2, 4'd0);
        set_req(3, 32'd9, 32'd9, 4'd0);
        #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        check("post_rst_id", 32'(bus.rsp_id), 32'd1);
        check("post_rst_data", bus.rsp_data, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
